// File: rtl/jtag_axi_pkg.sv
// Shared types and constants for the JTAG side of the JTAG-to-AXI bridge:
// instruction codes, DR selections and lengths, status codes, and the
// transaction-info / status-word layouts exchanged with jtag_axi_dispatch.
package jtag_axi_pkg;

  localparam int AXI_ADDR_WIDTH       = 32;
  localparam int AXI_DATA_WIDTH       = 32;
  localparam int AXI_ASYNC_FIFO_DEPTH = 4;
  localparam int AFIFO_CNT_W          = $clog2(AXI_ASYNC_FIFO_DEPTH + 1);

  typedef logic [AFIFO_CNT_W-1:0] axi_afifo_t;

  typedef enum logic [3:0] {
    IR_IDCODE = 4'd1,
    IR_ADDR   = 4'd4,
    IR_DATA_W = 4'd5,
    IR_CTRL   = 4'd6,
    IR_STATUS = 4'd7,
    IR_BYPASS = 4'hF
  } jtag_instr_t;

  // DR selection latched at Capture-DR; BYPASS is the all-zero reset choice.
  typedef enum logic [2:0] {
    DR_BYPASS = 3'd0,
    DR_IDCODE = 3'd1,
    DR_ADDR   = 3'd2,
    DR_DATA_W = 3'd3,
    DR_CTRL   = 3'd4,
    DR_STATUS = 3'd5
  } dr_sel_t;

  localparam int IDCODE_LEN = 32;
  localparam int ADDR_LEN   = AXI_ADDR_WIDTH;
  localparam int DATA_W_LEN = AXI_DATA_WIDTH;
  localparam int CTRL_LEN   = 5;
  localparam int STATUS_LEN = AXI_DATA_WIDTH + 4;
  localparam int BYPASS_LEN = 1;

  localparam int SR_W = (STATUS_LEN > ADDR_LEN)
                        ? ((STATUS_LEN > IDCODE_LEN) ? STATUS_LEN : IDCODE_LEN)
                        : ((ADDR_LEN > IDCODE_LEN) ? ADDR_LEN : IDCODE_LEN);
  localparam int LEN_W = $clog2(SR_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUNNING = 3'd1,
    ST_OKAY    = 3'd2,
    ST_EXOKAY  = 3'd3,
    ST_SLVERR  = 3'd4,
    ST_DECERR  = 3'd5,
    ST_TIMEOUT = 3'd6
  } jtag_status_e;

  typedef enum logic {
    TXN_RD = 1'b0,
    TXN_WR = 1'b1
  } txn_type_e;

  // CTRL DR layout, MSB first: {start, txn_type, size[2:0]}
  typedef struct packed {
    logic       start;
    txn_type_e  txn_type;
    logic [2:0] size;
  } s_axi_jtag_ctrl_t;

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_DATA_WIDTH-1:0] data_wr;
    s_axi_jtag_ctrl_t          ctrl;
  } s_axi_jtag_info_t;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data_rd;
    logic [2:0]                status;
  } s_axi_jtag_status_t;

  function automatic logic [LEN_W-1:0] dr_len(input dr_sel_t sel);
    case (sel)
      DR_IDCODE: return LEN_W'(IDCODE_LEN);
      DR_ADDR:   return LEN_W'(ADDR_LEN);
      DR_DATA_W: return LEN_W'(DATA_W_LEN);
      DR_CTRL:   return LEN_W'(CTRL_LEN);
      DR_STATUS: return LEN_W'(STATUS_LEN);
      default:   return LEN_W'(BYPASS_LEN);
    endcase
  endfunction

  // Terminal responses are the only ones dispatch expects to be popped.
  function automatic logic is_final(input logic [2:0] st);
    return (st == ST_OKAY) || (st == ST_EXOKAY) ||
           (st == ST_SLVERR) || (st == ST_DECERR);
  endfunction

endpackage

// File: rtl/jtag_axi_dr_ctrl.sv
// JTAG data-register bank for the JTAG-to-AXI bridge (tck domain).
// One shift register sized to the widest DR serves every instruction; the
// selected DR is latched at Capture-DR so IR changes mid-shift are ignored.
// Optional build macro: JTAG_AXI_IDCODE_EN enables the IDCODE instruction;
// without it IR=1 decodes as BYPASS.
module jtag_axi_dr_ctrl
  import jtag_axi_pkg::*;
#(
  parameter int          IR_WIDTH    = 4,
  parameter logic [31:0] IDCODE_VAL  = 32'h0BAD_C0DE,
  parameter int          AFIFO_DEPTH = AXI_ASYNC_FIFO_DEPTH
) (
  input  logic               tck,
  input  logic               trstn,
  input  logic [IR_WIDTH-1:0] ir_i,
  input  logic               capture_dr_i,
  input  logic               shift_dr_i,
  input  logic               update_dr_i,
  input  logic               tdi_i,
  output logic               tdo_o,
  input  s_axi_jtag_status_t jtag_status_i,
  input  axi_afifo_t         afifo_slots_i,
  output s_axi_jtag_info_t   axi_info_o,
  output logic               axi_req_new_o,
  output logic               axi_status_rd_o
);

  logic [SR_W-1:0]  sr_q;
  logic [SR_W-1:0]  sr_shifted;
  logic [LEN_W-1:0] msb_idx;
  dr_sel_t          dr_dec;
  dr_sel_t          dr_sel_q;
  s_axi_jtag_info_t info_q;
  logic             drop_ff;
  logic             status_final_ff;
  logic             req_q;
  logic             ack_q;

  // Decode the live instruction into a DR selection (used only at Capture).
  always_comb begin
    dr_dec = DR_BYPASS;
    if (ir_i == IR_WIDTH'(IR_ADDR))        dr_dec = DR_ADDR;
    else if (ir_i == IR_WIDTH'(IR_DATA_W)) dr_dec = DR_DATA_W;
    else if (ir_i == IR_WIDTH'(IR_CTRL))   dr_dec = DR_CTRL;
    else if (ir_i == IR_WIDTH'(IR_STATUS)) dr_dec = DR_STATUS;
`ifdef JTAG_AXI_IDCODE_EN
    else if (ir_i == IR_WIDTH'(IR_IDCODE)) dr_dec = DR_IDCODE;
`endif
  end

  // Right shift with tdi entering at the top bit of the latched DR length.
  always_comb begin
    msb_idx             = dr_len(dr_sel_q) - LEN_W'(1);
    sr_shifted          = sr_q >> 1;
    sr_shifted[msb_idx] = tdi_i;
  end

  // DR state machine: update has priority over capture, capture over shift.
  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      sr_q            <= '0;
      dr_sel_q        <= DR_BYPASS;
      info_q          <= '0;
      drop_ff         <= 1'b0;
      status_final_ff <= 1'b0;
      req_q           <= 1'b0;
      ack_q           <= 1'b0;
    end else begin
      req_q <= 1'b0;
      ack_q <= 1'b0;
      if (update_dr_i) begin
        case (dr_sel_q)
          DR_ADDR:   info_q.addr    <= sr_q[ADDR_LEN-1:0];
          DR_DATA_W: info_q.data_wr <= sr_q[DATA_W_LEN-1:0];
          DR_CTRL: begin
            info_q.ctrl <= s_axi_jtag_ctrl_t'(sr_q[CTRL_LEN-1:0]);
            if (sr_q[CTRL_LEN-1]) begin
              if (32'(afifo_slots_i) < AFIFO_DEPTH) req_q   <= 1'b1;
              else                                  drop_ff <= 1'b1;
            end
          end
          DR_STATUS: begin
            drop_ff <= 1'b0;
            ack_q   <= status_final_ff;
          end
          default: ;
        endcase
      end else if (capture_dr_i) begin
        dr_sel_q <= dr_dec;
        case (dr_dec)
          DR_ADDR:   sr_q <= SR_W'(info_q.addr);
          DR_DATA_W: sr_q <= SR_W'(info_q.data_wr);
          DR_CTRL:   sr_q <= SR_W'({1'b0, info_q.ctrl.txn_type, info_q.ctrl.size});
          DR_STATUS: begin
            sr_q <= SR_W'({drop_ff, jtag_status_i.status, jtag_status_i.data_rd});
            status_final_ff <= is_final(jtag_status_i.status);
          end
          DR_IDCODE: sr_q <= SR_W'(IDCODE_VAL);
          default:   sr_q <= '0;
        endcase
      end else if (shift_dr_i) begin
        sr_q <= sr_shifted;
      end
    end
  end

  assign tdo_o           = sr_q[0];
  assign axi_info_o      = info_q;
  assign axi_req_new_o   = req_q;
  assign axi_status_rd_o = ack_q;

endmodule

// File: tb/tb_jtag_axi_dr_ctrl.sv
// Self-checking bench for jtag_axi_dr_ctrl: a queue-based model of the
// selected data register is compared with the DUT on every falling edge,
// with directed scenarios plus randomized TAP-like traffic.
module tb_jtag_axi_dr_ctrl;
  import jtag_axi_pkg::*;

  localparam int DEPTH = AXI_ASYNC_FIFO_DEPTH;
  localparam int K_BYP = 0, K_ID = 1, K_ADDR = 2, K_DATA = 3, K_CTRL = 4, K_STAT = 5;

  logic               tck = 1'b0;
  logic               trstn = 1'b0;
  logic [3:0]         ir_i = 4'd0;
  logic               capture_dr_i = 1'b0, shift_dr_i = 1'b0, update_dr_i = 1'b0, tdi_i = 1'b0;
  logic               tdo_o;
  s_axi_jtag_status_t jtag_status_i = '0;
  axi_afifo_t         afifo_slots_i = '0;
  s_axi_jtag_info_t   axi_info_o;
  logic               axi_req_new_o, axi_status_rd_o;

  jtag_axi_dr_ctrl dut (
    .tck(tck), .trstn(trstn), .ir_i(ir_i),
    .capture_dr_i(capture_dr_i), .shift_dr_i(shift_dr_i), .update_dr_i(update_dr_i),
    .tdi_i(tdi_i), .tdo_o(tdo_o), .jtag_status_i(jtag_status_i),
    .afifo_slots_i(afifo_slots_i), .axi_info_o(axi_info_o),
    .axi_req_new_o(axi_req_new_o), .axi_status_rd_o(axi_status_rd_o)
  );

  always #5 tck = ~tck;

  int n_cmp = 0, n_bad = 0;
  int req_cnt = 0, ack_cnt = 0;
  bit started = 1'b0;

  // Model: the selected DR is a queue of bits, element 0 faces tdo.
  bit          mq[$];
  int          m_kind;
  logic [31:0] m_addr, m_data;
  logic [4:0]  m_ctrl;
  bit          m_drop, m_final;
  bit          exp_tdo, exp_req, exp_ack;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int kind_of(input logic [3:0] ir);
    case (ir)
      4'd4: return K_ADDR;
      4'd5: return K_DATA;
      4'd6: return K_CTRL;
      4'd7: return K_STAT;
`ifdef JTAG_AXI_IDCODE_EN
      4'd1: return K_ID;
`endif
      default: return K_BYP;
    endcase
  endfunction

  function automatic int len_of(input int k);
    case (k)
      K_ID, K_ADDR, K_DATA: return 32;
      K_CTRL: return 5;
      K_STAT: return 36;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    mq.push_back(1'b0);
    m_kind = K_BYP;
    m_addr = '0; m_data = '0; m_ctrl = '0;
    m_drop = 1'b0; m_final = 1'b0;
    exp_tdo = 1'b0; exp_req = 1'b0; exp_ack = 1'b0;
  endtask

  task automatic model_step();
    logic [63:0] v;
    exp_req = 1'b0;
    exp_ack = 1'b0;
    v = '0;
    if (update_dr_i) begin
      foreach (mq[i]) v[i] = mq[i];
      case (m_kind)
        K_ADDR: m_addr = v[31:0];
        K_DATA: m_data = v[31:0];
        K_CTRL: begin
          m_ctrl = v[4:0];
          if (v[4]) begin
            if (int'(afifo_slots_i) < DEPTH) exp_req = 1'b1;
            else m_drop = 1'b1;
          end
        end
        K_STAT: begin
          exp_ack = m_final;
          m_drop  = 1'b0;
        end
        default: ;
      endcase
    end else if (capture_dr_i) begin
      m_kind = kind_of(ir_i);
      case (m_kind)
        K_ADDR: v = 64'(m_addr);
        K_DATA: v = 64'(m_data);
        K_CTRL: v = 64'({1'b0, m_ctrl[3:0]});
        K_STAT: begin
          v = 64'({m_drop, jtag_status_i.status, jtag_status_i.data_rd});
          m_final = (jtag_status_i.status >= 3'd2) && (jtag_status_i.status <= 3'd5);
        end
        K_ID: v = 64'h0BAD_C0DE;
        default: v = '0;
      endcase
      mq.delete();
      for (int i = 0; i < len_of(m_kind); i++) mq.push_back(v[i]);
    end else if (shift_dr_i) begin
      void'(mq.pop_front());
      mq.push_back(tdi_i);
    end
    exp_tdo = mq[0];
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge tck) begin
    if (started) begin
      check("tdo", 128'(tdo_o), 128'(exp_tdo));
      check("req_new", 128'(axi_req_new_o), 128'(exp_req));
      check("status_rd", 128'(axi_status_rd_o), 128'(exp_ack));
      check("info", 128'(axi_info_o), 128'({m_addr, m_data, m_ctrl}));
      if (axi_req_new_o) req_cnt++;
      if (axi_status_rd_o) ack_cnt++;
    end
  end

  task automatic cyc(input logic [3:0] ir, input logic cap, input logic sh,
                     input logic upd, input logic td);
    ir_i = ir; capture_dr_i = cap; shift_dr_i = sh; update_dr_i = upd; tdi_i = td;
    @(posedge tck);
    if (trstn) model_step();
    @(negedge tck);
    #1;
  endtask

  task automatic shift_dr(input logic [3:0] ir, input int len, input logic [63:0] val,
                          input bit upd, output logic [63:0] out);
    out = '0;
    cyc(ir, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      out[i] = tdo_o;
      cyc(ir, 1'b0, 1'b1, 1'b0, val[i]);
    end
    if (upd) cyc(ir, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(ir, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [63:0] out;
    logic [3:0]  irs [8];
    int r0, a0;
    irs = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd15};

    model_reset();
    started = 1'b1;
    repeat (3) @(negedge tck);
    #1;
    check("rst_info", 128'(axi_info_o), 128'(0));
    check("rst_tdo", 128'(tdo_o), 128'(0));
    trstn = 1'b1;

    // IDCODE / BYPASS behaviour of IR=1
`ifdef JTAG_AXI_IDCODE_EN
    shift_dr(4'd1, 32, 64'd0, 1'b0, out);
    check("idcode_word", 128'(out[31:0]), 128'(32'h0BAD_C0DE));
`else
    cyc(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ir1_bypass_cap", 128'(tdo_o), 128'(0));
    cyc(4'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("ir1_bypass_echo1", 128'(tdo_o), 128'(1));
    cyc(4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ir1_bypass_echo0", 128'(tdo_o), 128'(0));
`endif
    cyc(4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(4'd15, 1'b0, 1'b1, 1'b0, 1'b1);
    check("bypass_echo", 128'(tdo_o), 128'(1));

    // ADDR write followed by a write request
    afifo_slots_i = '0;
    shift_dr(4'd4, 32, 64'h8000_0010, 1'b1, out);
    r0 = req_cnt;
    shift_dr(4'd6, 5, 64'b11010, 1'b1, out);
    check("req_one_pulse", 128'(req_cnt - r0), 128'(1));
    check("info_addr", 128'(axi_info_o.addr), 128'(32'h8000_0010));
    check("info_size", 128'(axi_info_o.ctrl.size), 128'(2));
    check("info_wr", 128'(axi_info_o.ctrl.txn_type), 128'(1));

    // FIFO full: request dropped, drop flag reported once
    afifo_slots_i = axi_afifo_t'(DEPTH);
    r0 = req_cnt;
    shift_dr(4'd6, 5, 64'b11010, 1'b1, out);
    check("full_no_req", 128'(req_cnt - r0), 128'(0));
    jtag_status_i.status = 3'd1;
    jtag_status_i.data_rd = 32'h0;
    a0 = ack_cnt;
    shift_dr(4'd7, 36, 64'd0, 1'b1, out);
    check("drop_set", 128'(out[35]), 128'(1));
    shift_dr(4'd7, 36, 64'd0, 1'b1, out);
    check("drop_clear", 128'(out[35]), 128'(0));
    check("running_no_ack", 128'(ack_cnt - a0), 128'(0));

    // OKAY status read and acknowledge
    jtag_status_i.status = 3'd2;
    jtag_status_i.data_rd = 32'hDEAD_BEEF;
    a0 = ack_cnt;
    shift_dr(4'd7, 36, 64'd0, 1'b1, out);
    check("status_data", 128'(out[31:0]), 128'(32'hDEAD_BEEF));
    check("status_code", 128'(out[34:32]), 128'(2));
    check("okay_ack", 128'(ack_cnt - a0), 128'(1));
    a0 = ack_cnt;
    shift_dr(4'd7, 36, 64'd0, 1'b0, out);
    check("no_update_no_ack", 128'(ack_cnt - a0), 128'(0));

    // IR changes from ADDR to CTRL mid-shift
    afifo_slots_i = '0;
    r0 = req_cnt;
    cyc(4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      logic [31:0] w;
      w = 32'h1234_5678;
      cyc((i < 16) ? 4'd4 : 4'd6, 1'b0, 1'b1, 1'b0, w[i]);
    end
    cyc(4'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    check("irchg_addr", 128'(axi_info_o.addr), 128'(32'h1234_5678));
    check("irchg_ctrl", 128'(axi_info_o.ctrl), 128'(5'b11010));
    check("irchg_no_req", 128'(req_cnt - r0), 128'(0));

    // Reset in the middle of a CTRL shift with start=1
    r0 = req_cnt;
    cyc(4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(4'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(4'd6, 1'b0, 1'b1, 1'b0, 1'b1);
    #2;
    trstn = 1'b0;
    model_reset();
    #1;
    check("midrst_info", 128'(axi_info_o), 128'(0));
    check("midrst_tdo", 128'(tdo_o), 128'(0));
    check("midrst_req", 128'(axi_req_new_o), 128'(0));
    cyc(4'd6, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(4'd6, 1'b0, 1'b1, 1'b0, 1'b1);
    trstn = 1'b1;
    cyc(4'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst_no_req", 128'(req_cnt - r0), 128'(0));

    // Randomized well-formed scans
    for (int t = 0; t < 150; t++) begin
      afifo_slots_i = axi_afifo_t'($urandom_range(0, DEPTH));
      jtag_status_i.status = 3'($urandom_range(0, 7));
      jtag_status_i.data_rd = $urandom;
      shift_dr(irs[$urandom_range(0, 7)], int'($urandom_range(0, 40)),
               {$urandom, $urandom}, ($urandom_range(0, 3) != 0), out);
    end

    // Randomized raw strobes, including overlapping ones
    for (int t = 0; t < 400; t++) begin
      afifo_slots_i = axi_afifo_t'($urandom_range(0, DEPTH));
      if ($urandom_range(0, 15) == 0) begin
        jtag_status_i.status = 3'($urandom_range(0, 7));
        jtag_status_i.data_rd = $urandom;
      end
      cyc(irs[$urandom_range(0, 7)], 1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
          1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
